// File: rtl/nmcu_pkg.sv
// Shared definitions for the NMCU command path: dimension-port widths,
// descriptor op encodings and the dispatch FSM state type.
package nmcu_pkg;

  // A dimension port must hold its maximum value, so it gets one bit above $clog2.
  function automatic int dim_width(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  localparam int DEF_MAX_INPUT_DIM  = 16;
  localparam int DEF_MAX_KERNEL_DIM = 7;
  localparam int DW = dim_width(DEF_MAX_INPUT_DIM);
  localparam int KW = dim_width(DEF_MAX_KERNEL_DIM);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_CONV = 2'b01,
    OP_MAXP = 2'b10,
    OP_RELU = 2'b11
  } nmcu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GEN,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } dispatch_state_e;

endpackage

// File: rtl/nmcu_dispatch_if.sv
// Host-side job command / response channel of nmcu_dispatch.
interface nmcu_dispatch_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_INPUT_DIM  = 16,
  parameter int MAX_KERNEL_DIM = 7
);
  import nmcu_pkg::*;

  localparam int DIM_W = dim_width(MAX_INPUT_DIM);
  localparam int KER_W = dim_width(MAX_KERNEL_DIM);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_desc;
  logic [ADDR_WIDTH-1:0] cmd_in_base;
  logic [ADDR_WIDTH-1:0] cmd_out_base;
  logic [DIM_W-1:0]      cmd_in_width;
  logic [DIM_W-1:0]      cmd_in_height;
  logic [KER_W-1:0]      cmd_kernel_dim;
  logic                  busy;
  logic                  rsp_valid;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_desc, cmd_in_base, cmd_out_base,
           cmd_in_width, cmd_in_height, cmd_kernel_dim,
    input  cmd_ready, busy, rsp_valid, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_desc, cmd_in_base, cmd_out_base,
           cmd_in_width, cmd_in_height, cmd_kernel_dim,
    output cmd_ready, busy, rsp_valid, rsp_err
  );

endinterface

// File: rtl/nmcu_addr_gen.sv
// Combinational window-address calculator for one grid slot (row, col).
// Addresses wrap silently modulo 2^ADDR_WIDTH; inactive slots read as zero.
module nmcu_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int DW         = 5,
  parameter int RCW        = 4
) (
  input  logic [RCW-1:0]        row,
  input  logic [RCW-1:0]        col,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [DW-1:0]         in_width,
  input  logic [DW-1:0]         out_width,
  input  logic [DW-1:0]         out_height,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  active
);

  localparam int CMPW = (RCW > DW) ? RCW : DW;

  logic [ADDR_WIDTH-1:0] row_x;
  logic [ADDR_WIDTH-1:0] col_x;

  assign row_x  = ADDR_WIDTH'(row);
  assign col_x  = ADDR_WIDTH'(col);
  assign active = (CMPW'(row) < CMPW'(out_height)) && (CMPW'(col) < CMPW'(out_width));

  always_comb begin
    in_addr  = '0;
    out_addr = '0;
    if (active) begin
      in_addr  = in_base  + row_x * ADDR_WIDTH'(in_width)  + col_x;
      out_addr = out_base + row_x * ADDR_WIDTH'(out_width) + col_x;
    end
  end

endmodule

// File: rtl/nmcu_dispatch.sv
// Job dispatcher for the NMCU array: validates a convolution job, fills the
// per-NMCU window address slots one per cycle, launches the active NMCUs and
// reports completion.
module nmcu_dispatch
  import nmcu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_INPUT_DIM  = 16,
  parameter int MAX_KERNEL_DIM = 7,
  parameter int OUTPUT_DIM     = 14,
  localparam int DIM_W     = dim_width(MAX_INPUT_DIM),
  localparam int NUM_NMCUS = OUTPUT_DIM * OUTPUT_DIM
) (
  input  logic                            clk,
  input  logic                            rst,
  nmcu_dispatch_if.slave                  host,
  output logic [ADDR_WIDTH-1:0]           nmcu_desc,
  output logic [DIM_W-1:0]                full_input_width,
  output logic [DIM_W-1:0]                full_input_height,
  output logic [DIM_W-1:0]                full_output_width,
  output logic [DIM_W-1:0]                full_output_height,
  output logic [NUM_NMCUS*ADDR_WIDTH-1:0] input_addr_flat,
  output logic [NUM_NMCUS*ADDR_WIDTH-1:0] output_addr_flat,
  output logic [NUM_NMCUS-1:0]            nmcu_start,
  input  logic [NUM_NMCUS-1:0]            nmcu_done
);

  localparam int KER_W = dim_width(MAX_KERNEL_DIM);
  localparam int RCW   = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1;
  localparam int SW    = (NUM_NMCUS > 1) ? $clog2(NUM_NMCUS) : 1;
  localparam int CW    = ((DIM_W > KER_W) ? DIM_W : KER_W) + 2;

  dispatch_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0] desc_reg, in_base_reg, out_base_reg;
  logic [DIM_W-1:0]      in_w_reg, in_h_reg, out_w_reg, out_h_reg;
  logic [KER_W-1:0]      k_reg;
  logic                  err_reg;
  logic [RCW-1:0]        row_reg, col_reg;
  logic [SW-1:0]         slot_reg;

  logic [ADDR_WIDTH-1:0] in_addr_reg  [NUM_NMCUS];
  logic [ADDR_WIDTH-1:0] out_addr_reg [NUM_NMCUS];
  logic                  active_reg   [NUM_NMCUS];
  logic [NUM_NMCUS-1:0]  active_mask;

  logic [CW-1:0]         k_x, w_x, h_x, ow_x, oh_x;
  logic                  check_err;
  logic                  all_done;
  logic                  last_slot;
  logic [ADDR_WIDTH-1:0] gen_in_addr, gen_out_addr;
  logic                  gen_active;

  assign k_x  = CW'(k_reg);
  assign w_x  = CW'(in_w_reg);
  assign h_x  = CW'(in_h_reg);
  assign ow_x = w_x - k_x + CW'(1);
  assign oh_x = h_x - k_x + CW'(1);

  // The output-size terms are only meaningful once k fits; the k terms cover underflow.
  assign check_err = (k_x == '0) || (k_x > CW'(MAX_KERNEL_DIM)) ||
                     (k_x > w_x) || (k_x > h_x) ||
                     (w_x > CW'(MAX_INPUT_DIM)) || (h_x > CW'(MAX_INPUT_DIM)) ||
                     (ow_x > CW'(OUTPUT_DIM)) || (oh_x > CW'(OUTPUT_DIM));

  assign last_slot = (slot_reg == SW'(NUM_NMCUS - 1));
  assign all_done  = &(nmcu_done | ~active_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (host.cmd_valid) state_next = ST_CHECK;
      ST_CHECK:  state_next = check_err ? ST_RESP : ST_GEN;
      ST_GEN:    if (last_slot) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (all_done) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      desc_reg     <= '0;
      in_base_reg  <= '0;
      out_base_reg <= '0;
      in_w_reg     <= '0;
      in_h_reg     <= '0;
      out_w_reg    <= '0;
      out_h_reg    <= '0;
      k_reg        <= '0;
      err_reg      <= 1'b0;
      row_reg      <= '0;
      col_reg      <= '0;
      slot_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (host.cmd_valid) begin
            desc_reg     <= host.cmd_desc;
            in_base_reg  <= host.cmd_in_base;
            out_base_reg <= host.cmd_out_base;
            in_w_reg     <= host.cmd_in_width;
            in_h_reg     <= host.cmd_in_height;
            k_reg        <= host.cmd_kernel_dim;
            err_reg      <= 1'b0;
          end
        end
        ST_CHECK: begin
          err_reg   <= check_err;
          out_w_reg <= check_err ? '0 : DIM_W'(ow_x);
          out_h_reg <= check_err ? '0 : DIM_W'(oh_x);
          row_reg   <= '0;
          col_reg   <= '0;
          slot_reg  <= '0;
        end
        ST_GEN: begin
          slot_reg <= slot_reg + SW'(1);
          if (col_reg == RCW'(OUTPUT_DIM - 1)) begin
            col_reg <= '0;
            row_reg <= row_reg + RCW'(1);
          end else begin
            col_reg <= col_reg + RCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  nmcu_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DW         (DIM_W),
    .RCW        (RCW)
  ) u_addr_gen (
    .row        (row_reg),
    .col        (col_reg),
    .in_base    (in_base_reg),
    .out_base   (out_base_reg),
    .in_width   (in_w_reg),
    .out_width  (out_w_reg),
    .out_height (out_h_reg),
    .in_addr    (gen_in_addr),
    .out_addr   (gen_out_addr),
    .active     (gen_active)
  );

  // Each slot captures the calculator output only in its own GEN cycle.
  for (genvar gi = 0; gi < NUM_NMCUS; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        in_addr_reg[gi]  <= '0;
        out_addr_reg[gi] <= '0;
        active_reg[gi]   <= 1'b0;
      end else if (state_reg == ST_GEN && slot_reg == SW'(gi)) begin
        in_addr_reg[gi]  <= gen_in_addr;
        out_addr_reg[gi] <= gen_out_addr;
        active_reg[gi]   <= gen_active;
      end
    end
    assign input_addr_flat[gi*ADDR_WIDTH +: ADDR_WIDTH]  = in_addr_reg[gi];
    assign output_addr_flat[gi*ADDR_WIDTH +: ADDR_WIDTH] = out_addr_reg[gi];
    assign active_mask[gi] = active_reg[gi];
  end

  assign nmcu_start = (state_reg == ST_LAUNCH || state_reg == ST_WAIT) ? active_mask : '0;

  assign host.cmd_ready = (state_reg == ST_IDLE);
  assign host.busy      = (state_reg != ST_IDLE);
  assign host.rsp_valid = (state_reg == ST_RESP);
  assign host.rsp_err   = (state_reg == ST_RESP) && err_reg;

  assign nmcu_desc          = desc_reg;
  assign full_input_width   = in_w_reg;
  assign full_input_height  = in_h_reg;
  assign full_output_width  = out_w_reg;
  assign full_output_height = out_h_reg;

endmodule

// File: tb/tb_nmcu_dispatch.sv
// Directed bench for nmcu_dispatch: geometry, slot addresses, latency,
// stale-done handling, error jobs, address wrap and mid-job reset.
module tb_nmcu_dispatch;
  import nmcu_pkg::*;

  localparam int AW  = 16;
  localparam int OD  = 14;
  localparam int NUM = OD * OD;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   nmcu_desc;
  logic [4:0]      full_input_width, full_input_height;
  logic [4:0]      full_output_width, full_output_height;
  logic [NUM*AW-1:0] input_addr_flat, output_addr_flat;
  logic [NUM-1:0]  nmcu_start;
  logic [NUM-1:0]  nmcu_done;

  int errors = 0;
  int checks = 0;
  int lat;
  logic [NUM-1:0] exp_mask;

  nmcu_dispatch_if #(.ADDR_WIDTH(AW), .MAX_INPUT_DIM(16), .MAX_KERNEL_DIM(7)) host ();

  nmcu_dispatch #(
    .ADDR_WIDTH(AW), .MAX_INPUT_DIM(16), .MAX_KERNEL_DIM(7), .OUTPUT_DIM(OD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .host               (host),
    .nmcu_desc          (nmcu_desc),
    .full_input_width   (full_input_width),
    .full_input_height  (full_input_height),
    .full_output_width  (full_output_width),
    .full_output_height (full_output_height),
    .input_addr_flat    (input_addr_flat),
    .output_addr_flat   (output_addr_flat),
    .nmcu_start         (nmcu_start),
    .nmcu_done          (nmcu_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] in_slot(input int n);
    return input_addr_flat[n*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] out_slot(input int n);
    return output_addr_flat[n*AW +: AW];
  endfunction

  function automatic logic [NUM-1:0] mask_of(input int ow, input int oh);
    logic [NUM-1:0] m;
    m = '0;
    for (int n = 0; n < NUM; n++) m[n] = ((n / OD) < oh) && ((n % OD) < ow);
    return m;
  endfunction

  task automatic send(input logic [AW-1:0] desc, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                      input int w, input int h, input int k);
    @(negedge clk);
    check("accept_ready", host.cmd_ready, 1);
    host.cmd_desc       = desc;
    host.cmd_in_base    = ib;
    host.cmd_out_base   = ob;
    host.cmd_in_width   = 5'(w);
    host.cmd_in_height  = 5'(h);
    host.cmd_kernel_dim = 4'(k);
    host.cmd_valid      = 1'b1;
    @(posedge clk);
    #1 host.cmd_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until start or a response is visible.
  task automatic wait_start(output int n);
    n = 1;
    @(negedge clk);
    while (nmcu_start == '0 && !host.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_job(input string tag, input logic [NUM-1:0] done_val);
    int n;
    nmcu_done = done_val;
    n = 0;
    while (!host.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, host.rsp_valid, 1);
    check({tag, "_rsp_err"}, host.rsp_err, 0);
    $display("job %s completed, rsp_err=%0b after %0d wait cycles", tag, host.rsp_err, n);
    @(negedge clk);
    check({tag, "_idle_ready"}, host.cmd_ready, 1);
    nmcu_done = '0;
  endtask

  initial begin
    rst = 1'b0;
    nmcu_done = '0;
    host.cmd_valid = 1'b0;
    host.cmd_desc = '0;
    host.cmd_in_base = '0;
    host.cmd_out_base = '0;
    host.cmd_in_width = '0;
    host.cmd_in_height = '0;
    host.cmd_kernel_dim = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", host.cmd_ready, 1);
    check("rst_busy", host.busy, 0);
    check("rst_rsp", host.rsp_valid, 0);
    check("rst_start", $countones(nmcu_start), 0);
    check("rst_slot0", in_slot(0), 0);
    check("rst_outw", full_output_width, 0);
    rst = 1'b1;

    // Full 16x16 k=3 job: whole grid active.
    send(16'h0000, 16'h0100, 16'h0200, 16, 16, 3);
    wait_start(lat);
    check("t1_lat", lat, 198);
    check("t1_cnt", $countones(nmcu_start), 196);
    check("t1_in15", in_slot(15), 16'h0111);
    check("t1_out15", out_slot(15), 16'h020F);
    check("t1_in195", in_slot(195), 16'h01DD);
    check("t1_out195", out_slot(195), 16'h02C3);
    check("t1_outw", full_output_width, 14);
    check("t1_outh", full_output_height, 14);
    check("t1_inw", full_input_width, 16);
    check("t1_busy", host.busy, 1);
    check("t1_ready", host.cmd_ready, 0);
    @(negedge clk);
    check("t1_hold", host.rsp_valid, 0);
    finish_job("t1", {NUM{1'b1}});
    check("t1_keep_in15", in_slot(15), 16'h0111);

    // 8x6 k=3: partial grid, inactive done bits held low.
    send(16'h0040, 16'h0100, 16'h0200, 8, 6, 3);
    wait_start(lat);
    exp_mask = mask_of(6, 4);
    check("t2_lat", lat, 198);
    check("t2_mask", 32'(nmcu_start == exp_mask), 1);
    check("t2_cnt", $countones(nmcu_start), 24);
    check("t2_in14", in_slot(14), 16'h0108);
    check("t2_out14", out_slot(14), 16'h0206);
    check("t2_in6", in_slot(6), 16'h0000);
    check("t2_out6", out_slot(6), 16'h0000);
    check("t2_outw", full_output_width, 6);
    check("t2_outh", full_output_height, 4);
    check("t2_desc", nmcu_desc, 16'h0040);
    nmcu_done = mask_of(6, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_partial", host.rsp_valid, 0);
    end
    finish_job("t2", exp_mask);

    // Rejected jobs: kernel larger than input, input wider than max.
    send(16'h0000, 16'h0100, 16'h0200, 4, 4, 5);
    wait_start(lat);
    check("t3a_lat", lat, 2);
    check("t3a_rsp", host.rsp_valid, 1);
    check("t3a_err", host.rsp_err, 1);
    check("t3a_start", $countones(nmcu_start), 0);
    $display("job t3a rejected, rsp_err=%0b latency=%0d", host.rsp_err, lat);
    send(16'h0000, 16'h0100, 16'h0200, 17, 16, 3);
    wait_start(lat);
    check("t3b_lat", lat, 2);
    check("t3b_err", host.rsp_err, 1);
    check("t3b_start", $countones(nmcu_start), 0);
    $display("job t3b rejected, rsp_err=%0b latency=%0d", host.rsp_err, lat);

    // Stale done from before the job must not complete it in LAUNCH.
    nmcu_done = {NUM{1'b1}};
    send(16'h0000, 16'h0300, 16'h0400, 4, 4, 2);
    wait_start(lat);
    check("t4_lat", lat, 198);
    check("t4_cnt", $countones(nmcu_start), 9);
    check("t4_launch_rsp", host.rsp_valid, 0);
    @(negedge clk);
    check("t4_wait_rsp", host.rsp_valid, 0);
    @(negedge clk);
    check("t4_resp", host.rsp_valid, 1);
    check("t4_err", host.rsp_err, 0);
    $display("job t4 completed two cycles after start");
    @(negedge clk);
    nmcu_done = '0;

    // Input address wrap, then asynchronous reset during WAIT.
    send(16'h0000, 16'hFFF0, 16'h0000, 16, 16, 3);
    wait_start(lat);
    check("t5_in0", in_slot(0), 16'hFFF0);
    check("t5_in1", in_slot(1), 16'hFFF1);
    check("t5_in14", in_slot(14), 16'h0000);
    @(negedge clk);
    check("t6_busy_wait", host.busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_start", $countones(nmcu_start), 0);
    check("t6_busy", host.busy, 0);
    check("t6_rsp", host.rsp_valid, 0);
    check("t6_ready", host.cmd_ready, 1);
    check("t6_slot0", in_slot(0), 0);
    $display("job t5 aborted by reset");
    @(negedge clk);
    rst = 1'b1;
    send(16'h0000, 16'h0500, 16'h0600, 4, 4, 2);
    wait_start(lat);
    check("t6_lat", lat, 198);
    check("t6_mask", 32'(nmcu_start == mask_of(3, 3)), 1);
    check("t6_in15", in_slot(15), 16'h0505);
    check("t6_out15", out_slot(15), 16'h0604);
    finish_job("t6", mask_of(3, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
